// File: rtl/game_session_ctrl_if.sv
// Handshake bundle between the menu/gameplay logic and the game session controller.
// The master side drives the request and event pulses; the slave side reports session status.
interface game_session_ctrl_if #(
  parameter int SCORE_W = 16
);
  logic               i_frame;
  logic               i_main_start;
  logic               i_hit;
  logic               i_pass;
  logic               o_main_ready;
  logic               o_return_menu;
  logic               o_playing;
  logic               o_invuln;
  logic [SCORE_W-1:0] o_score;
  logic [3:0]         o_lives;
  logic [2:0]         o_state;

  modport master (
    output i_frame, i_main_start, i_hit, i_pass,
    input  o_main_ready, o_return_menu, o_playing, o_invuln, o_score, o_lives, o_state
  );

  modport slave (
    input  i_frame, i_main_start, i_hit, i_pass,
    output o_main_ready, o_return_menu, o_playing, o_invuln, o_score, o_lives, o_state
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Game session sequencer: init delay, frame-aligned start, scoring, lives with hit
// immunity, game-over hold and hand-back to the menu. All outputs are registered.
module game_session_ctrl #(
  parameter int INIT_CYCLES = 1024,
  parameter int LIVES       = 3,
  parameter int INV_FRAMES  = 60,
  parameter int OVER_FRAMES = 180,
  parameter int SCORE_W     = 16
) (
  input  logic                i_clk_pix,
  input  logic                i_rst_n,
  game_session_ctrl_if.slave  bus
);

  localparam int CYC_W   = $clog2(INIT_CYCLES + 1);
  localparam int FRM_MAX = (INV_FRAMES > OVER_FRAMES) ? INV_FRAMES : OVER_FRAMES;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(INIT_CYCLES - 1);
  localparam logic [FRM_W-1:0] INV_LAST   = FRM_W'(INV_FRAMES - 1);
  localparam logic [FRM_W-1:0] OVER_LAST  = FRM_W'(OVER_FRAMES - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    READY  = 3'd2,
    PLAY   = 3'd3,
    OVER   = 3'd4,
    RETURN = 3'd5
  } state_t;

  state_t             state_reg;
  logic [CYC_W-1:0]   cyc_cnt_reg;
  logic [FRM_W-1:0]   frame_cnt_reg;
  logic [SCORE_W-1:0] score_reg;
  logic [3:0]         lives_reg;
  logic               main_ready_reg;
  logic               return_menu_reg;
  logic               playing_reg;
  logic               invuln_reg;

  logic in_session;
  assign in_session = (state_reg == INIT) || (state_reg == READY) ||
                      (state_reg == PLAY) || (state_reg == OVER);

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      cyc_cnt_reg     <= '0;
      frame_cnt_reg   <= '0;
      score_reg       <= '0;
      lives_reg       <= '0;
      main_ready_reg  <= 1'b0;
      return_menu_reg <= 1'b0;
      playing_reg     <= 1'b0;
      invuln_reg      <= 1'b0;
    end else if (in_session && !bus.i_main_start) begin
      // Menu withdrew the request: silent abort, score and lives stay on display.
      state_reg       <= IDLE;
      main_ready_reg  <= 1'b0;
      return_menu_reg <= 1'b0;
      playing_reg     <= 1'b0;
      invuln_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_main_start) begin
            state_reg     <= INIT;
            score_reg     <= '0;
            lives_reg     <= LIVES_INIT;
            cyc_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            invuln_reg    <= 1'b0;
          end
        end
        INIT: begin
          if (cyc_cnt_reg == CYC_LAST) begin
            state_reg      <= READY;
            main_ready_reg <= 1'b1;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        READY: begin
          if (bus.i_frame) begin
            state_reg   <= PLAY;
            playing_reg <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.i_pass && (score_reg != '1))
            score_reg <= score_reg + 1'b1;
          if (bus.i_hit && !invuln_reg) begin
            lives_reg     <= lives_reg - 1'b1;
            frame_cnt_reg <= '0;
            if (lives_reg == 4'd1) begin
              state_reg   <= OVER;
              playing_reg <= 1'b0;
            end else begin
              invuln_reg <= 1'b1;
            end
          end else if (invuln_reg && bus.i_frame) begin
            // Counter parks on its last value so it never wraps inside PLAY.
            if (frame_cnt_reg == INV_LAST)
              invuln_reg <= 1'b0;
            else
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        OVER: begin
          if (bus.i_frame) begin
            if (frame_cnt_reg == OVER_LAST) begin
              state_reg       <= RETURN;
              main_ready_reg  <= 1'b0;
              return_menu_reg <= 1'b1;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
          end
        end
        RETURN: begin
          if (!bus.i_main_start) begin
            state_reg       <= IDLE;
            return_menu_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          main_ready_reg  <= 1'b0;
          return_menu_reg <= 1'b0;
          playing_reg     <= 1'b0;
          invuln_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_state       = state_reg;
  assign bus.o_main_ready  = main_ready_reg;
  assign bus.o_return_menu = return_menu_reg;
  assign bus.o_playing     = playing_reg;
  assign bus.o_invuln      = invuln_reg;
  assign bus.o_score       = score_reg;
  assign bus.o_lives       = lives_reg;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl: directed sessions followed by random play,
// checked cycle by cycle against a rule-level reference model.
module tb_game_session_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int LIVES       = 2;
  localparam int INV_FRAMES  = 2;
  localparam int OVER_FRAMES = 3;
  localparam int SCORE_W     = 4;
  localparam int SMAX        = (1 << SCORE_W) - 1;

  localparam int P_IDLE = 0, P_INIT = 1, P_READY = 2, P_PLAY = 3, P_OVER = 4, P_RETURN = 5;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_pix = ~clk_pix;

  game_session_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  game_session_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .LIVES       (LIVES),
    .INV_FRAMES  (INV_FRAMES),
    .OVER_FRAMES (OVER_FRAMES),
    .SCORE_W     (SCORE_W)
  ) dut (
    .i_clk_pix (clk_pix),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int st;
    int rdy;
    int ret;
    int ply;
    int inv;
    int score;
    int lives;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle_no = 0;

  // Reference model: phase plus "remaining" budgets, derived from the session rules.
  int m_phase = P_IDLE;
  int m_score = 0;
  int m_lives = 0;
  int m_inv   = 0;
  int m_init_left = 0;
  int m_inv_left  = 0;
  int m_over_left = 0;

  task automatic model_abort();
    m_phase = P_IDLE;
    m_inv   = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit fr, input bit ht, input bit ps);
    if (!r) begin
      m_phase = P_IDLE; m_score = 0; m_lives = 0; m_inv = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (st) begin
          m_phase = P_INIT; m_score = 0; m_lives = LIVES; m_inv = 0;
          m_init_left = INIT_CYCLES;
        end
        P_INIT: if (!st) model_abort();
          else begin
            m_init_left--;
            if (m_init_left == 0) m_phase = P_READY;
          end
        P_READY: if (!st) model_abort();
          else if (fr) m_phase = P_PLAY;
        P_PLAY: if (!st) model_abort();
          else begin
            if (ps) m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
            if (ht && m_inv == 0) begin
              m_lives--;
              if (m_lives == 0) begin
                m_phase = P_OVER; m_over_left = OVER_FRAMES;
              end else begin
                m_inv = 1; m_inv_left = INV_FRAMES;
              end
            end else if (m_inv == 1 && fr) begin
              m_inv_left--;
              if (m_inv_left == 0) m_inv = 0;
            end
          end
        P_OVER: if (!st) model_abort();
          else if (fr) begin
            m_over_left--;
            if (m_over_left == 0) m_phase = P_RETURN;
          end
        P_RETURN: if (!st) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit fr, input bit ht, input bit ps);
    exp_t e;
    @(negedge clk_pix);
    rst_n            = r;
    bus.i_main_start = st;
    bus.i_frame      = fr;
    bus.i_hit        = ht;
    bus.i_pass       = ps;
    model_step(r, st, fr, ht, ps);
    e.st    = m_phase;
    e.rdy   = (m_phase == P_READY || m_phase == P_PLAY || m_phase == P_OVER) ? 1 : 0;
    e.ret   = (m_phase == P_RETURN) ? 1 : 0;
    e.ply   = (m_phase == P_PLAY) ? 1 : 0;
    e.inv   = m_inv;
    e.score = m_score;
    e.lives = m_lives;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d required %0d", name, cycle_no, act, req);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare against the oldest expectation.
  initial begin : monitor
    exp_t e;
    logic [2:0] prev_st;
    prev_st = 3'd7;
    forever begin
      @(posedge clk_pix);
      #2;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",       32'(bus.o_state),       e.st);
        chk("main_ready",  32'(bus.o_main_ready),  e.rdy);
        chk("return_menu", 32'(bus.o_return_menu), e.ret);
        chk("playing",     32'(bus.o_playing),     e.ply);
        chk("invuln",      32'(bus.o_invuln),      e.inv);
        chk("score",       32'(bus.o_score),       e.score);
        chk("lives",       32'(bus.o_lives),       e.lives);
        if (bus.o_state !== prev_st)
          $display("txn cycle %0d: state %0d score %0d lives %0d", cycle_no, bus.o_state,
                   bus.o_score, bus.o_lives);
        prev_st = bus.o_state;
      end
    end
  end

  initial begin : driver
    bus.i_main_start = 1'b0;
    bus.i_frame      = 1'b0;
    bus.i_hit        = 1'b0;
    bus.i_pass       = 1'b0;

    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);

    // Session 1: start latency, scoring, immunity, fatal hit with pass, game over, return.
    repeat (5) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (11) cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Session 2: score saturation, then abort from PLAY.
    repeat (5) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (17) cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // Session 3: immunity expires, second hit is fatal, reset lands in OVER.
    repeat (5) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // Random play; the start request drops occasionally to exercise aborts and returns.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 99) < 97),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0));
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk_pix);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
